// File: rtl/dcache_pkg.sv
// Shared types and geometry helpers for the direct-mapped write-through data cache.
package dcache_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REFILL,
    WRITE
  } state_t;

  localparam int offset_width   = 2;
  localparam int words_per_line = 4;

  function automatic int index_width_of(input int num_lines);
    return $clog2(num_lines);
  endfunction

  function automatic int tag_width_of(input int address_width, input int num_lines);
    return address_width - offset_width - $clog2(num_lines);
  endfunction

endpackage

// File: rtl/dcache_array.sv
// Valid/tag/data storage, one line per index; combinational read, line fill and word update.
// Latency: reads are combinational, writes land at the clock edge; no backpressure.
module dcache_array
  import dcache_pkg::*;
#(
  parameter int data_width = 32,
  parameter int line_width = 128,
  parameter int num_lines  = 16,
  parameter int tag_width  = 4
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [index_width_of(num_lines)-1:0] index,
  input  logic [offset_width-1:0]              offset,
  output logic                                 rd_valid,
  output logic [tag_width-1:0]                 rd_tag,
  output logic [data_width-1:0]                rd_word,
  input  logic                                 fill_en,
  input  logic [tag_width-1:0]                 fill_tag,
  input  logic [line_width-1:0]                fill_line,
  input  logic                                 word_en,
  input  logic [data_width-1:0]                word_data
);

  logic [num_lines-1:0]                            valid;
  logic [tag_width-1:0]                            tags [num_lines];
  logic [words_per_line-1:0][data_width-1:0]       data [num_lines];

  // Only the valid bits are reset; stale tags/data are masked by valid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid <= '0;
    end else if (fill_en) begin
      valid[index] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_en) begin
      tags[index] <= fill_tag;
      data[index] <= fill_line;
    end else if (word_en) begin
      data[index][offset] <= word_data;
    end
  end

  assign rd_valid = valid[index];
  assign rd_tag   = tags[index];
  assign rd_word  = data[index][offset];

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-through no-write-allocate D-cache controller.
// Latency: read hit 0 stalls, read miss 6, store 5; CPU is stalled while memory is busy.
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int data_width    = 32,
  parameter int line_width    = 128,
  parameter int address_width = 10,
  parameter int num_lines     = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cpu_read,
  input  logic                     cpu_write,
  input  logic [address_width-1:0] cpu_addr,
  input  logic [data_width-1:0]    cpu_wdata,
  output logic [data_width-1:0]    cpu_rdata,
  output logic                     cpu_stall,
  output logic                     mem_read,
  output logic                     mem_write,
  output logic [address_width-1:0] mem_addr,
  output logic [data_width-1:0]    mem_wdata,
  input  logic [line_width-1:0]    mem_line,
  input  logic                     mem_ready
);

  localparam int index_width = index_width_of(num_lines);
  localparam int tag_width   = tag_width_of(address_width, num_lines);

  logic [offset_width-1:0] offset;
  logic [index_width-1:0]  index;
  logic [tag_width-1:0]    tag;

  assign offset = cpu_addr[offset_width-1:0];
  assign index  = cpu_addr[offset_width +: index_width];
  assign tag    = cpu_addr[address_width-1 -: tag_width];

  state_t                  state;
  logic [line_width-1:0]   line_buf;
  logic                    line_valid;
  logic [tag_width-1:0]    line_tag;
  logic [data_width-1:0]   cached_word;
  logic                    hit;
  logic                    fill_en;
  logic                    word_en;

  assign hit     = line_valid && (line_tag == tag);
  assign fill_en = (state == REFILL) && mem_ready;
  assign word_en = (state == IDLE) && cpu_write && hit;

  dcache_array #(
    .data_width (data_width),
    .line_width (line_width),
    .num_lines  (num_lines),
    .tag_width  (tag_width)
  ) u_array (
    .clk       (clk),
    .reset     (reset),
    .index     (index),
    .offset    (offset),
    .rd_valid  (line_valid),
    .rd_tag    (line_tag),
    .rd_word   (cached_word),
    .fill_en   (fill_en),
    .fill_tag  (tag),
    .fill_line (line_buf),
    .word_en   (word_en),
    .word_data (cpu_wdata)
  );

  // The CPU holds its request through the miss, so index/tag stay valid for the fill.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      line_buf <= '0;
    end else begin
      if (mem_read) begin
        line_buf <= mem_line;
      end
      case (state)
        IDLE: begin
          if (cpu_write) begin
            state <= WRITE;
          end else if (cpu_read && !hit) begin
            state <= REFILL;
          end
        end
        REFILL: if (mem_ready) state <= IDLE;
        WRITE:  if (mem_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Requests drop in the ready cycle so the memory's counter never restarts mid-line.
  always_comb begin
    cpu_rdata = '0;
    cpu_stall = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (!reset) begin
      case (state)
        IDLE: begin
          cpu_stall = cpu_write || (cpu_read && !hit);
          if (cpu_read && !cpu_write && hit) begin
            cpu_rdata = cached_word;
          end
        end
        REFILL: begin
          cpu_stall = 1'b1;
          mem_read  = !mem_ready;
          mem_addr  = {tag, index, {offset_width{1'b0}}};
        end
        WRITE: begin
          cpu_stall = !mem_ready;
          mem_write = !mem_ready;
          mem_addr  = cpu_addr;
          mem_wdata = cpu_wdata;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Scoreboard bench for dcache_ctrl with a 4-cycle line memory model.
module tb_dcache_ctrl;

  logic         clk = 1'b0;
  logic         reset;
  logic         cpu_read;
  logic         cpu_write;
  logic [9:0]   cpu_addr;
  logic [31:0]  cpu_wdata;
  logic [31:0]  cpu_rdata;
  logic         cpu_stall;
  logic         mem_read;
  logic         mem_write;
  logic [9:0]   mem_addr;
  logic [31:0]  mem_wdata;
  logic [127:0] mem_line;
  logic         mem_ready;

  always #5 clk = ~clk;

  dcache_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_read  (cpu_read),
    .cpu_write (cpu_write),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_stall (cpu_stall),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_line  (mem_line),
    .mem_ready (mem_ready)
  );

  // Memory: word a holds 0xC0DE0000|a after reset; ready follows 4 request edges.
  logic [31:0] mem [1024];
  int          mem_cnt;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_cnt   <= 0;
      mem_ready <= 1'b0;
      for (int i = 0; i < 1024; i++) mem[i] <= 32'hC0DE0000 | 32'(i);
    end else begin
      mem_ready <= 1'b0;
      if (mem_read || mem_write) begin
        if (mem_cnt == 3) begin
          mem_ready <= 1'b1;
          mem_cnt   <= 0;
          if (mem_write) mem[mem_addr] <= mem_wdata;
        end else begin
          mem_cnt <= mem_cnt + 1;
        end
      end else begin
        mem_cnt <= 0;
      end
    end
  end

  assign mem_line = mem_read ? {mem[{mem_addr[9:2], 2'd3}], mem[{mem_addr[9:2], 2'd2}],
                                mem[{mem_addr[9:2], 2'd1}], mem[{mem_addr[9:2], 2'd0}]}
                             : {4{32'hBAD0BAD0}};

  typedef struct {
    bit          is_write;
    logic [31:0] data;
    int          stalls;
    int          mcyc;
    logic [9:0]  maddr;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: accumulates per-request activity and retires it when the stall drops.
  int          mon_stalls;
  int          mon_rd;
  int          mon_wr;
  logic [9:0]  mon_maddr;
  logic [31:0] mon_wd;
  exp_t        mon_e;

  initial begin
    mon_stalls = 0; mon_rd = 0; mon_wr = 0; mon_maddr = '0; mon_wd = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        mon_stalls = 0; mon_rd = 0; mon_wr = 0; mon_maddr = '0; mon_wd = '0;
      end else if (cpu_read || cpu_write) begin
        if (mem_read) begin
          mon_rd++;
          mon_maddr = mem_addr;
        end
        if (mem_write) begin
          mon_wr++;
          mon_maddr = mem_addr;
          mon_wd    = mem_wdata;
        end
        if (cpu_stall) begin
          mon_stalls++;
        end else if (sb.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL sb_unexpected: completion at addr 0x%0h with empty queue", cpu_addr);
        end else begin
          mon_e = sb.pop_front();
          chk(mon_e.is_write ? "store_wdata" : "load_rdata",
              mon_e.is_write ? mon_wd : cpu_rdata, mon_e.data);
          chk("stall_cycles", mon_stalls, mon_e.stalls);
          chk("mem_read_cycles", mon_rd, mon_e.is_write ? 0 : mon_e.mcyc);
          chk("mem_write_cycles", mon_wr, mon_e.is_write ? mon_e.mcyc : 0);
          chk("mem_addr", 32'(mon_maddr), 32'(mon_e.maddr));
          mon_stalls = 0; mon_rd = 0; mon_wr = 0; mon_maddr = '0; mon_wd = '0;
        end
      end
    end
  end

  task automatic wait_done();
    bit done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (!cpu_stall) done = 1'b1;
    end
    if (!done) chk("req_timeout", 32'(cpu_stall), 32'd0);
  endtask

  task automatic push_exp(input bit wr, input logic [31:0] data, input int stalls,
                          input logic [9:0] maddr);
    exp_t e;
    e.is_write = wr;
    e.data     = data;
    e.stalls   = stalls;
    e.mcyc     = (stalls == 0) ? 0 : 4;
    e.maddr    = maddr;
    sb.push_back(e);
  endtask

  task automatic req(input bit wr, input logic [9:0] addr, input logic [31:0] wdata,
                     input logic [31:0] exp_data, input int exp_stalls, input logic [9:0] exp_maddr);
    push_exp(wr, exp_data, exp_stalls, exp_maddr);
    @(posedge clk);
    #1;
    cpu_read  = !wr;
    cpu_write = wr;
    cpu_addr  = addr;
    cpu_wdata = wr ? wdata : 32'h0;
    wait_done();
  endtask

  task automatic idle_check();
    @(posedge clk);
    #1;
    cpu_read = 1'b0; cpu_write = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    @(negedge clk);
    chk("idle_stall", 32'(cpu_stall), 32'd0);
    chk("idle_mem_addr", 32'(mem_addr), 32'd0);
    chk("idle_cpu_rdata", cpu_rdata, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset with a load held: every output must stay quiet.
    reset = 1'b1; cpu_read = 1'b1; cpu_write = 1'b0; cpu_addr = 10'h005; cpu_wdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_mem_read", 32'(mem_read), 32'd0);
    chk("rst_mem_write", 32'(mem_write), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_cpu_rdata", cpu_rdata, 32'd0);
    chk("rst_cpu_stall", 32'(cpu_stall), 32'd0);
    @(posedge clk);
    #1;
    cpu_read = 1'b0; cpu_addr = '0;
    reset = 1'b0;
    idle_check();

    req(1'b0, 10'h005, 32'h0, 32'hC0DE0005, 6, 10'h004);       // cold miss
    req(1'b0, 10'h006, 32'h0, 32'hC0DE0006, 0, 10'h000);       // hit same line
    req(1'b1, 10'h007, 32'hDEADBEEF, 32'hDEADBEEF, 5, 10'h007); // store hit
    req(1'b0, 10'h007, 32'h0, 32'hDEADBEEF, 0, 10'h000);       // updated word
    req(1'b1, 10'h3F0, 32'h12345678, 32'h12345678, 5, 10'h3F0); // store miss
    req(1'b0, 10'h3F0, 32'h0, 32'h12345678, 6, 10'h3F0);       // no allocate
    idle_check();
    req(1'b0, 10'h045, 32'h0, 32'hC0DE0045, 6, 10'h044);       // evicts 0x004 line
    req(1'b0, 10'h005, 32'h0, 32'hC0DE0005, 6, 10'h004);       // misses again
    req(1'b0, 10'h007, 32'h0, 32'hDEADBEEF, 0, 10'h000);       // store reached memory
    idle_check();

    // Reset in the second refill cycle of a miss to 0x105.
    @(posedge clk);
    #1;
    cpu_read = 1'b1; cpu_write = 1'b0; cpu_addr = 10'h105;
    repeat (2) @(posedge clk);
    #1;
    chk("pre_reset_mem_read", 32'(mem_read), 32'd1);
    reset = 1'b1;
    #1;
    chk("mid_reset_mem_read", 32'(mem_read), 32'd0);
    chk("mid_reset_stall", 32'(cpu_stall), 32'd0);
    cpu_addr = 10'h005;
    @(posedge clk);
    #1;
    push_exp(1'b0, 32'hC0DE0005, 6, 10'h004);
    reset = 1'b0;
    wait_done();
    req(1'b0, 10'h006, 32'h0, 32'hC0DE0006, 0, 10'h000);
    idle_check();

    repeat (3) @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/dcache_ctrl.md
# dcache_ctrl

Direct-mapped, write-through, no-write-allocate data cache controller between the CPU load/store port and the line-based data memory. Serves read hits in the same cycle. Refills a 4-word line from the data memory on a read miss. Forwards every store to memory while stalling the CPU. It also shapes the memory request so that the memory's 4-cycle `ready` counter is never left mid-count.

## Interface
Parameters:
- `data_width`, 32, CPU word width
- `line_width`, 128, line width (4 words)
- `address_width`, 10, word address width
- `num_lines`, 16, cache lines; index = log2(`num_lines`) bits

Ports:
- `clk`, in, 1, clock
- `reset`, in, 1, asynchronous, active-high
- `cpu_read`, in, 1, load request; held stable while `cpu_stall`=1
- `cpu_write`, in, 1, store request; held stable while `cpu_stall`=1
- `cpu_addr`, in, `address_width`, word address
- `cpu_wdata`, in, `data_width`, store data
- `cpu_rdata`, out, `data_width`, load data; valid when `cpu_read` & ~`cpu_stall`
- `cpu_stall`, out, 1, CPU must hold request
- `mem_read`, out, 1, line read request
- `mem_write`, out, 1, word write request
- `mem_addr`, out, `address_width`, memory word address
- `mem_wdata`, out, `data_width`, memory write data
- `mem_line`, in, `line_width`, line from memory; valid only while `mem_read`=1
- `mem_ready`, in, 1, one-cycle completion pulse from memory

## Operation
- Address split: offset=`cpu_addr[1:0]`, index=next log2(`num_lines`) bits, tag=remaining MSBs.
- hit = valid[index] & (tag_array[index]==tag).
- FSM states: IDLE, REFILL, WRITE.
  - IDLE + `cpu_write`: go to WRITE. On a hit, also update the cached word at this edge. On a miss, the cache is unchanged.
  - IDLE + `cpu_read` & ~hit: go to REFILL.
  - IDLE + `cpu_read` & hit: stay in IDLE; `cpu_rdata` = cached word (combinational).
  - `cpu_write` & `cpu_read` together: write wins.
- REFILL:
  - `mem_addr`={tag,index,2'b00}.
  - Each cycle `mem_read`=1, the line buffer register captures `mem_line`.
  - On `mem_ready`: write the buffer into data[index], set tag and valid, go to IDLE.
- WRITE:
  - `mem_addr`=`cpu_addr`, `mem_wdata`=`cpu_wdata`.
  - On `mem_ready`: go to IDLE.
- `mem_read`=(state==REFILL)&~`mem_ready`.
- `mem_write`=(state==WRITE)&~`mem_ready`.
- The request drops in the ready cycle, so the memory counter ends at 0.
- `cpu_stall`=(IDLE & (`cpu_write` | (`cpu_read`&~hit))) | REFILL | (WRITE & ~`mem_ready`).
- `mem_ready` in IDLE is ignored.
- Reset (any time, including mid-REFILL/WRITE):
  - state→IDLE; all valid bits→0; line buffer→0.
  - Data and tag arrays are not reset.
  - Outputs: `mem_read`=0, `mem_write`=0, `mem_addr`=0, `mem_wdata`=0, `cpu_rdata`=0, `cpu_stall`=0 (no request).
- Outputs with no request in IDLE: `mem_addr`=0, `mem_wdata`=0, `cpu_rdata`=0.

## Timing
- Memory contract: `ready` pulses in the cycle after the 4th consecutive edge with a request held.
- Read hit: 0 stall cycles; data in the request cycle.
- Read miss:
  - Cycle 0: detect miss (stall).
  - Cycles 1–4: `mem_read`=1.
  - Cycle 5: `mem_ready`, `mem_read`=0, fill at the edge ending cycle 5; stall remains high.
  - Cycle 6: hit, stall low, data out. Total 6 stall cycles.
- Write (hit or miss):
  - Cycle 0: stall.
  - Cycles 1–4: `mem_write`=1.
  - Cycle 5: `mem_ready`, stall low, store retires. Total 5 stall cycles.
- Back-to-back: a new request in the cycle after completion starts a fresh 4-cycle memory transaction.

## Structure
- `dcache_pkg` holds:
  - state enum (IDLE/REFILL/WRITE)
  - localparams for offset/index/tag widths
  - words-per-line constant (4)
- Sub-module `dcache_array`:
  - holds valid/tag/data storage with async valid clear
  - provides a combinational read port
  - provides write ports for full-line fill and single-word update
- The top level holds the FSM, the line buffer and the request shaping.

## Test plan
- Reset, then read addr 0x005: miss. `mem_read` high for 4 cycles with `mem_addr`=0x004, then `cpu_rdata`=mem[0x005] in cycle 6.
- Read 0x006 after that fill: hit with zero stall; `cpu_rdata`=mem[0x006].
- Write 0x007=0xDEADBEEF (hit), then read 0x007: `mem_write` held 4 cycles, stall 5 cycles, read hit returns 0xDEADBEEF.
- Write 0x3F0 (miss), then read 0x3F0: no cache update; read misses and refills a line containing 0xDEADBEEF-style written data from memory.
- Alias: read 0x005, then 0x045 (same index, different tag): second read misses, refills, and evicts. A read of 0x005 then misses again.
- Assert reset during REFILL cycle 2: `mem_read`=0 and stall=0 immediately. After release, read 0x005 misses (valid cleared), and the refill takes exactly 4 memory cycles.
